wormhole_output_arbiter: RTL

- Per-output-port controller for the router switch.
- Arbitrates among the N_IN input-port circular buffers competing for one output, using round-robin with wormhole packet lock.
- Generates one-hot pop strobes to the buffers and the crossbar mux select.
- Enforces credit-based flow control toward the downstream buffer.

---
 rtl/wormhole_output_arbiter_if.sv | 39 +++
 rtl/wormhole_output_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/wormhole_output_arbiter_if.sv
// Signal bundle between one output-port arbiter and its input buffers/downstream.
// err_o is present only when ARB_CREDIT_CHECK_EN is defined.
interface wormhole_output_arbiter_if #(
  parameter int N_IN = 5
);
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0]  req_i;
  logic [N_IN-1:0]  empty_i;
  logic [N_IN-1:0]  tail_i;
  logic             credit_i;
  logic [N_IN-1:0]  read_o;
  logic [SEL_W-1:0] sel_o;
  logic             valid_o;
  logic             busy_o;
  logic [7:0]       credit_cnt_o;

`ifdef ARB_CREDIT_CHECK_EN
  logic             err_o;

  modport master (
    output req_i, empty_i, tail_i, credit_i,
    input  read_o, sel_o, valid_o, busy_o, credit_cnt_o, err_o
  );
  modport slave (
    input  req_i, empty_i, tail_i, credit_i,
    output read_o, sel_o, valid_o, busy_o, credit_cnt_o, err_o
  );
`else
  modport master (
    output req_i, empty_i, tail_i, credit_i,
    input  read_o, sel_o, valid_o, busy_o, credit_cnt_o
  );
  modport slave (
    input  req_i, empty_i, tail_i, credit_i,
    output read_o, sel_o, valid_o, busy_o, credit_cnt_o
  );
`endif
endinterface

// File: rtl/wormhole_output_arbiter.sv
// Per-output round-robin arbiter with wormhole lock and downstream credit counting.
// Optional macro ARB_CREDIT_CHECK_EN adds a sticky protocol error flag (err_o).
module wormhole_output_arbiter #(
  parameter int N_IN    = 5,
  parameter int CREDITS = 8
) (
  input  logic clk,
  input  logic rst,
  wormhole_output_arbiter_if.slave bus
);
  localparam int         SEL_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [7:0] CRED_MAX = 8'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_owner;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [7:0]       r_cnt;

  logic [N_IN-1:0]  w_elig;
  logic [N_IN-1:0]  w_read;
  logic             w_any_elig;
  logic             w_xfer;
  logic [SEL_W-1:0] w_winner;

  assign w_elig     = bus.req_i & ~bus.empty_i;
  assign w_any_elig = |w_elig;
  assign w_xfer     = (r_state == LOCKED) && !bus.empty_i[r_owner] && (r_cnt != 8'd0);

  // Scan rr_ptr+1 .. rr_ptr+N_IN (mod N_IN); first eligible index wins.
  always_comb begin : rr_scan
    logic [SEL_W:0] v_idx;
    logic           v_found;
    w_winner = '0;
    v_found  = 1'b0;
    v_idx    = '0;
    for (int k = 1; k <= N_IN; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
      if (v_idx >= (SEL_W+1)'(N_IN)) begin
        v_idx = v_idx - (SEL_W+1)'(N_IN);
      end
      if (!v_found && w_elig[v_idx[SEL_W-1:0]]) begin
        w_winner = v_idx[SEL_W-1:0];
        v_found  = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_read
    assign w_read[gi] = w_xfer && (r_owner == SEL_W'(gi));
  end

  assign bus.read_o       = w_read;
  assign bus.valid_o      = w_xfer;
  assign bus.sel_o        = r_owner;
  assign bus.busy_o       = (r_state == LOCKED);
  assign bus.credit_cnt_o = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= SEL_W'(N_IN - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_elig) begin
            r_owner <= w_winner;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          // The tail pop releases the lock and demotes the owner to lowest priority.
          if (w_xfer && bus.tail_i[r_owner]) begin
            r_state  <= IDLE;
            r_rr_ptr <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A credit arriving when already full is dropped (saturation).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CRED_MAX;
    end else if (w_xfer && !bus.credit_i) begin
      r_cnt <= r_cnt - 8'd1;
    end else if (!w_xfer && bus.credit_i && (r_cnt != CRED_MAX)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

`ifdef ARB_CREDIT_CHECK_EN
  logic r_err;
  logic w_credit_ovf;
  logic w_route_chg;

  assign w_credit_ovf = bus.credit_i && !w_xfer && (r_cnt == CRED_MAX);
  assign w_route_chg  = (r_state == LOCKED) && !bus.req_i[r_owner] && !bus.empty_i[r_owner];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_credit_ovf || w_route_chg) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`endif

endmodule
